// File: rtl/mem_dumper_pkg.sv
// ---------------------------------------------------------------------------
// mem_dumper_pkg
//   Shared definitions for the memory dumper and its UART transmitter.
//   The UART frame constants are the same ones the program loader's receiver
//   uses, so both ends of the link agree on the frame layout.
//   Contents:
//     START_BIT / STOP_BIT / DATA_BITS / FRAME_BITS : 8N1 frame layout
//     ADR_W                                         : external memory bus width
//     rd_state_e                                    : read FSM state encoding
//     adr_inc()                                     : address increment with wrap
// ---------------------------------------------------------------------------
package mem_dumper_pkg;

    // 8N1 frame: one start bit, eight data bits LSB first, one stop bit.
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = DATA_BITS + 2;

    // External memory address width.
    localparam int   ADR_W      = 21;

    // Read FSM: IDLE -> READ -> LATCH -> WAITBUF -> READ ... -> IDLE.
    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_READ    = 2'd1,
        RD_LATCH   = 2'd2,
        RD_WAITBUF = 2'd3
    } rd_state_e;

    // Next dump address; wraps 0x1FFFFF -> 0x000000 naturally at ADR_W bits.
    function automatic logic [ADR_W-1:0] adr_inc(input logic [ADR_W-1:0] a);
        return a + ADR_W'(1);
    endfunction

endpackage : mem_dumper_pkg

// File: rtl/mem_dumper_uart_tx.sv
// ---------------------------------------------------------------------------
// mem_dumper_uart_tx
//   8N1 UART transmitter, LSB first. Takes a byte when valid && ready and
//   drives the start bit on tx one cycle later. Every bit lasts exactly
//   CLKS_PER_BIT cycles. ready is also high in the final cycle of the stop
//   bit, so a waiting byte starts its frame with no idle gap.
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous, active-high reset (tx returns to idle high)
//     data   in   byte to send, captured on take
//     valid  in   data is available
//     ready  out  transmitter can take a byte this cycle
//     tx     out  serial line, idle high
// ---------------------------------------------------------------------------
module mem_dumper_uart_tx
    import mem_dumper_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int               IDX_W    = $clog2(FRAME_BITS);
    // Bit index 0 is the start bit, 1..8 the data bits, 9 the stop bit.
    localparam logic [IDX_W-1:0] IDX_STOP = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_D7   = IDX_W'(FRAME_BITS - 2);

    logic                 active_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;

    logic bit_end;
    logic frame_end;

    assign bit_end   = (cnt_q == CNT_LAST);
    assign frame_end = active_q && bit_end && (idx_q == IDX_STOP);
    assign ready     = !active_q || frame_end;
    assign tx        = tx_q;

    // NOTE: state registers use non-blocking (<=) assignments so every
    // register samples the pre-edge values; blocking (=) here would make the
    // result depend on statement order and mismatch gate-level behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= STOP_BIT;
        end else if (valid && ready) begin
            // Take: start bit goes out next cycle, even straight after a stop bit.
            active_q <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= data;
            tx_q     <= START_BIT;
        end else if (active_q) begin
            if (bit_end) begin
                cnt_q <= '0;
                if (idx_q == IDX_STOP) begin
                    active_q <= 1'b0;
                    tx_q     <= STOP_BIT;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_D7) begin
                        tx_q <= STOP_BIT;
                    end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule : mem_dumper_uart_tx

// File: rtl/mem_dumper.sv
// ---------------------------------------------------------------------------
// mem_dumper
//   Reads the inclusive address range [base_adr .. last_adr] (wrapping at
//   2^21) from the external memory bus and streams each byte out as an 8N1
//   UART frame. A one-byte buffer lets the next byte be fetched while the
//   current one is shifting, so frames are back to back.
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous, active-high reset
//     start     in   one-cycle pulse, begins a dump; ignored while busy
//     abort     in   level; stop after the frame(s) already committed
//     base_adr  in   first address, sampled on start
//     last_adr  in   last address (inclusive), sampled on start
//     adr       out  memory address
//     read      out  memory read strobe, active high
//     din       in   memory read data
//     tx        out  UART TX line, idle high
//     busy      out  high from the cycle after start until the last stop bit ends
//     done      out  one-cycle pulse when the dump (or abort) completes
// ---------------------------------------------------------------------------
module mem_dumper
    import mem_dumper_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int READ_WAIT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADR_W-1:0]     base_adr,
    input  logic [ADR_W-1:0]     last_adr,
    output logic [ADR_W-1:0]     adr,
    output logic                 read,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int                WAIT_W    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

    rd_state_e            state_q;
    logic [ADR_W-1:0]     cur_q;
    logic [ADR_W-1:0]     cur_d;
    logic [ADR_W-1:0]     end_q;
    logic [ADR_W-1:0]     adr_q;
    logic                 read_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [DATA_BITS-1:0] buf_q;
    logic                 buf_full_q;
    logic                 fetch_done_q;
    logic                 abort_seen_q;
    logic                 busy_q;
    logic                 done_q;

    logic tx_ready;
    logic tx_take;
    logic abort_now;
    logic finish;

    assign cur_d     = adr_inc(cur_q);
    assign tx_take   = buf_full_q && tx_ready;
    // Abort is a level, but a short pulse during a read must still stop the
    // dump, so it is remembered for the rest of the current request.
    assign abort_now = abort || abort_seen_q;
    // Everything fetched, nothing buffered, and the shifter is idle or in the
    // last cycle of its stop bit with nothing to take next.
    assign finish    = fetch_done_q && !buf_full_q && tx_ready;

    assign adr  = adr_q;
    assign read = read_q;
    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RD_IDLE;
            cur_q        <= '0;
            end_q        <= '0;
            adr_q        <= '0;
            read_q       <= 1'b0;
            wait_q       <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            fetch_done_q <= 1'b0;
            abort_seen_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (busy_q && abort) begin
                abort_seen_q <= 1'b1;
            end

            // NOTE: buf_full_q is written in two places below; both live in
            // this one always_ff so there is a single driver, and the FSM's
            // set (LATCH) can never coincide with a take (buffer empty then).
            if (tx_take) begin
                buf_full_q <= 1'b0;
            end

            if (finish) begin
                done_q       <= 1'b1;
                busy_q       <= 1'b0;
                fetch_done_q <= 1'b0;
            end

            unique case (state_q)
                RD_IDLE: begin
                    // done_q high means this is the completion cycle; a start
                    // coinciding with it is dropped.
                    if (start && !busy_q && !done_q) begin
                        cur_q        <= base_adr;
                        end_q        <= last_adr;
                        busy_q       <= 1'b1;
                        abort_seen_q <= 1'b0;
                        fetch_done_q <= 1'b0;
                        adr_q        <= base_adr;
                        read_q       <= 1'b1;
                        wait_q       <= '0;
                        state_q      <= RD_READ;
                    end
                end

                RD_READ: begin
                    // A read in progress always runs to completion, even on abort.
                    if (wait_q == WAIT_LAST) begin
                        buf_q   <= din;
                        read_q  <= 1'b0;
                        state_q <= RD_LATCH;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                RD_LATCH: begin
                    buf_full_q <= 1'b1;
                    if ((cur_q == end_q) || abort_now) begin
                        fetch_done_q <= 1'b1;
                        state_q      <= RD_IDLE;
                    end else begin
                        cur_q   <= cur_d;
                        state_q <= RD_WAITBUF;
                    end
                end

                RD_WAITBUF: begin
                    // The buffered byte is still sent on abort; only the next
                    // read is cancelled.
                    if (abort_now) begin
                        fetch_done_q <= 1'b1;
                        state_q      <= RD_IDLE;
                    end else if (!buf_full_q) begin
                        adr_q   <= cur_q;
                        read_q  <= 1'b1;
                        wait_q  <= '0;
                        state_q <= RD_READ;
                    end
                end

                default: state_q <= RD_IDLE;
            endcase
        end
    end

    mem_dumper_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .data  (buf_q),
        .valid (buf_full_q),
        .ready (tx_ready),
        .tx    (tx)
    );

endmodule : mem_dumper

// File: tb/tb_mem_dumper.sv
// ---------------------------------------------------------------------------
// tb_mem_dumper
//   Directed bench for mem_dumper with CLKS_PER_BIT=4, READ_WAIT=2 and an
//   SRAM model returning mem[a] = a[7:0] ^ 0x5A. A monitor process decodes
//   the tx line into bytes, logs read-pulse addresses, done pulses and busy
//   time; the main sequence compares these against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_dumper;

    localparam int CPB   = 4;
    localparam int RWAIT = 2;
    localparam int FRAME = 10 * CPB;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [20:0] base_adr;
    logic [20:0] last_adr;
    logic [20:0] adr;
    logic        read;
    logic [7:0]  din;
    logic        tx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state (written only by the monitor process).
    int          cyc          = 0;
    logic        rx_active    = 1'b0;
    int          rx_start     = 0;
    logic [7:0]  rx_byte      = '0;
    logic [7:0]  rx_q[$];
    int          fs_q[$];
    logic [20:0] rd_q[$];
    int          done_cnt     = 0;
    int          done_cyc     = 0;
    int          bad_stop     = 0;
    int          busy_cycles  = 0;
    int          adr_changes  = 0;
    int          read_run     = 0;
    int          max_read_run = 0;
    logic        read_prev    = 1'b0;
    logic [20:0] adr_prev     = '0;

    mem_dumper #(
        .CLKS_PER_BIT (CPB),
        .READ_WAIT    (RWAIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .base_adr (base_adr),
        .last_adr (last_adr),
        .adr      (adr),
        .read     (read),
        .din      (din),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    // SRAM model.
    assign din = adr[7:0] ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample every falling edge.
    initial begin
        forever begin
            int off;
            int k;
            @(negedge clk);
            cyc++;
            if (reset) begin
                rx_active = 1'b0;
                read_prev = 1'b0;
                read_run  = 0;
                adr_prev  = adr;
            end else begin
                if (read) begin
                    read_run++;
                    if (read_run > max_read_run) max_read_run = read_run;
                    if (!read_prev) rd_q.push_back(adr);
                end else begin
                    read_run = 0;
                end
                read_prev = read;
                if (adr !== adr_prev) adr_changes++;
                adr_prev = adr;
                if (busy) busy_cycles++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (!rx_active) begin
                    if (tx === 1'b0) begin
                        rx_active = 1'b1;
                        rx_start  = cyc;
                        fs_q.push_back(cyc);
                    end
                end else begin
                    off = cyc - rx_start;
                    if (off % CPB == CPB / 2) begin
                        k = off / CPB;
                        if (k >= 1 && k <= 8) rx_byte[k-1] = tx;
                        if (k == 9) begin
                            if (tx !== 1'b1) bad_stop++;
                            rx_q.push_back(rx_byte);
                            rx_active = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [20:0] b, input logic [20:0] l);
        @(negedge clk);
        base_adr = b;
        last_adr = l;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, fb, sb, db, bb, ab;
        int n;
        logic [7:0] exp1 [3] = '{8'h4A, 8'h4B, 8'h48};
        logic [7:0] exp3 [4] = '{8'hA4, 8'hA5, 8'h5A, 8'h5B};
        logic [20:0] adr3 [4] = '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001};
        logic [7:0] exp4 [3] = '{8'h5A, 8'h5B, 8'h58};
        logic [7:0] exp6 [3] = '{8'h1A, 8'h1B, 8'h18};

        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        base_adr = '0;
        last_adr = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_tx",   {31'd0, tx},   32'd1);
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_adr",  {11'd0, adr},  32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: three bytes 0x10..0x12.
        rb = rd_q.size(); fb = rx_q.size(); sb = fs_q.size(); db = done_cnt;
        do_start(21'h10, 21'h12);
        wait_done("t1", 400);
        @(negedge clk);
        check("t1_nreads", rd_q.size() - rb, 32'd3);
        for (int i = 0; i < 3; i++) check("t1_read_adr", {11'd0, rd_q[rb+i]}, 32'h10 + i);
        check("t1_nframes", rx_q.size() - fb, 32'd3);
        for (int i = 0; i < 3; i++) check("t1_byte", {24'd0, rx_q[fb+i]}, {24'd0, exp1[i]});
        check("t1_gap01", fs_q[sb+1] - fs_q[sb], FRAME);
        check("t1_gap12", fs_q[sb+2] - fs_q[sb+1], FRAME);
        n = done_cyc - fs_q[sb];
        check("t1_done_latency_120_or_121", {31'd0, (n == 120 || n == 121)}, 32'd1);
        repeat (20) @(negedge clk);
        check("t1_done_once", done_cnt - db, 32'd1);

        // 2: single byte at the top address.
        rb = rd_q.size(); fb = rx_q.size(); db = done_cnt; bb = busy_cycles; ab = adr_changes;
        do_start(21'h1FFFFF, 21'h1FFFFF);
        wait_done("t2", 200);
        @(negedge clk);
        check("t2_nreads", rd_q.size() - rb, 32'd1);
        check("t2_read_adr", {11'd0, rd_q[rb]}, 32'h1FFFFF);
        check("t2_nframes", rx_q.size() - fb, 32'd1);
        check("t2_byte", {24'd0, rx_q[fb]}, 32'hA5);
        check("t2_adr_changes", adr_changes - ab, 32'd1);
        check("t2_adr_final", {11'd0, adr}, 32'h1FFFFF);
        // 4 cycles of fetch latency + one 40-cycle frame.
        check("t2_busy_cycles", busy_cycles - bb, 32'd44);
        check("t2_done_once", done_cnt - db, 32'd1);

        // 3: dump across the address wrap.
        rb = rd_q.size(); fb = rx_q.size(); db = done_cnt;
        do_start(21'h1FFFFE, 21'h000001);
        wait_done("t3", 400);
        repeat (10) @(negedge clk);
        check("t3_nreads", rd_q.size() - rb, 32'd4);
        for (int i = 0; i < 4; i++) check("t3_read_adr", {11'd0, rd_q[rb+i]}, {11'd0, adr3[i]});
        check("t3_nframes", rx_q.size() - fb, 32'd4);
        for (int i = 0; i < 4; i++) check("t3_byte", {24'd0, rx_q[fb+i]}, {24'd0, exp3[i]});
        check("t3_done_once", done_cnt - db, 32'd1);

        // 4: abort in the middle of frame 2 of a 10-byte dump.
        rb = rd_q.size(); fb = rx_q.size(); sb = fs_q.size(); db = done_cnt;
        do_start(21'h100, 21'h109);
        n = 0;
        while (fs_q.size() < sb + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t4_frame2_started", {31'd0, fs_q.size() >= sb + 2}, 32'd1);
        repeat (16) @(negedge clk);
        abort = 1'b1;
        wait_done("t4", 300);
        @(negedge clk);
        abort = 1'b0;
        n = rx_q.size() - fb;
        check("t4_nframes_2_or_3", {31'd0, (n == 2 || n == 3)}, 32'd1);
        check("t4_reads_eq_frames", rd_q.size() - rb, n);
        for (int i = 0; i < 3; i++)
            if (i < n) check("t4_byte", {24'd0, rx_q[fb+i]}, {24'd0, exp4[i]});
        rb = rd_q.size(); fb = rx_q.size();
        repeat (100) @(negedge clk);
        check("t4_no_more_reads", rd_q.size() - rb, 32'd0);
        check("t4_no_more_frames", rx_q.size() - fb, 32'd0);
        check("t4_busy_low", {31'd0, busy}, 32'd0);
        check("t4_done_once", done_cnt - db, 32'd1);

        // 5: reset in the middle of a frame, then a clean dump.
        do_start(21'h20, 21'h2F);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("t5_pre_tx_low", {31'd0, tx}, 32'd0);
        check("t5_pre_read_high", {31'd0, read}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_tx", {31'd0, tx}, 32'd1);
        check("t5_rst_read", {31'd0, read}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_adr", {11'd0, adr}, 32'd0);
        rb = rd_q.size(); fb = rx_q.size(); db = done_cnt;
        do_start(21'h20, 21'h21);
        wait_done("t5", 300);
        @(negedge clk);
        check("t5_nreads", rd_q.size() - rb, 32'd2);
        check("t5_read0", {11'd0, rd_q[rb]}, 32'h20);
        check("t5_nframes", rx_q.size() - fb, 32'd2);
        check("t5_byte0", {24'd0, rx_q[fb]}, 32'h7A);
        check("t5_byte1", {24'd0, rx_q[fb+1]}, 32'h7B);
        check("t5_done_once", done_cnt - db, 32'd1);

        // 6: a second start while busy is ignored.
        rb = rd_q.size(); fb = rx_q.size(); db = done_cnt;
        do_start(21'h40, 21'h42);
        repeat (2) @(negedge clk);
        base_adr = 21'h80;
        last_adr = 21'h90;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6", 400);
        repeat (10) @(negedge clk);
        check("t6_nreads", rd_q.size() - rb, 32'd3);
        for (int i = 0; i < 3; i++) check("t6_read_adr", {11'd0, rd_q[rb+i]}, 32'h40 + i);
        check("t6_nframes", rx_q.size() - fb, 32'd3);
        for (int i = 0; i < 3; i++) check("t6_byte", {24'd0, rx_q[fb+i]}, {24'd0, exp6[i]});
        check("t6_done_once", done_cnt - db, 32'd1);
        check("max_read_run", max_read_run, RWAIT);
        check("stop_bits_ok", bad_stop, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_dumper
